// File: rtl/unified_mem_if.sv
// Request/response bundle between a requester and unified_mem_ctrl: one instruction
// fetch port and one load/store port, each a valid/ready request plus a one-cycle response.
interface unified_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    localparam int BYTES = DATA_W / 8;

    logic              i_req_valid;
    logic              i_req_ready;
    logic [ADDR_W-1:0] i_req_addr;
    logic              i_rsp_valid;
    logic [DATA_W-1:0] i_rsp_data;
    logic              i_rsp_err;

    logic              d_req_valid;
    logic              d_req_ready;
    logic              d_req_we;
    logic [BYTES-1:0]  d_req_be;
    logic [ADDR_W-1:0] d_req_addr;
    logic [DATA_W-1:0] d_req_wdata;
    logic              d_rsp_valid;
    logic [DATA_W-1:0] d_rsp_rdata;
    logic              d_rsp_err;

    modport master (
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
        output d_req_valid, d_req_we, d_req_be, d_req_addr, d_req_wdata,
        input  d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
    );

    modport slave (
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_rsp_valid, i_rsp_data, i_rsp_err,
        input  d_req_valid, d_req_we, d_req_be, d_req_addr, d_req_wdata,
        output d_req_ready, d_rsp_valid, d_rsp_rdata, d_rsp_err
    );
endinterface

// File: rtl/unified_mem_ctrl.sv
// Unified instruction/data word memory: fetch and load/store ports, byte-strobe stores,
// address error responses, fixed read latency and optional shared single array port.
module unified_mem_ctrl #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int DEPTH_WORDS = 16384,
    parameter int RD_LATENCY  = 1,
    parameter bit SINGLE_PORT = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    unified_mem_if.slave bus
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam int HI    = OFF_W + IDX_W;
    localparam int NP    = 2;  // port 0 = load/store, port 1 = fetch

    genvar gi;

    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("unified_mem_ctrl: RD_LATENCY must be in 1..4");
    end
    if (DATA_W % 8 != 0 || DATA_W < 8) begin : g_bad_width
        $error("unified_mem_ctrl: DATA_W must be a non-zero multiple of 8");
    end
    if (DEPTH_WORDS < 2 || (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_bad_depth
        $error("unified_mem_ctrl: DEPTH_WORDS must be a power of 2");
    end

    logic [DATA_W-1:0] mem [DEPTH_WORDS];

    logic [NP-1:0]     req_valid;
    logic [NP-1:0]     req_err;
    logic [NP-1:0]     grant;
    logic [NP-1:0]     acc;
    logic [NP-1:0]     rd_en;
    logic [ADDR_W-1:0] req_addr [NP];
    logic [IDX_W-1:0]  req_idx  [NP];
    logic [NP-1:0]     rsp_valid;
    logic [NP-1:0]     rsp_err;
    logic [DATA_W-1:0] rsp_data [NP];
    logic              wr_en;
    logic              run_reg;
    logic              ptr_reg;  // 0: data port wins next contest, 1: fetch port

    assign req_valid   = {bus.i_req_valid, bus.d_req_valid};
    assign req_addr[0] = bus.d_req_addr;
    assign req_addr[1] = bus.i_req_addr;

    for (gi = 0; gi < NP; gi++) begin : g_decode
        logic misaligned;
        logic out_of_range;
        if (OFF_W > 0) begin : g_off
            assign misaligned = |req_addr[gi][OFF_W-1:0];
        end else begin : g_no_off
            assign misaligned = 1'b0;
        end
        // Any set bit above the array span means addr >= DEPTH_WORDS*BYTES.
        if (HI < ADDR_W) begin : g_hi
            assign out_of_range = |req_addr[gi][ADDR_W-1:HI];
        end else begin : g_no_hi
            assign out_of_range = 1'b0;
        end
        assign req_err[gi] = misaligned | out_of_range;
        assign req_idx[gi] = req_addr[gi][OFF_W +: IDX_W];
    end

    always_comb begin
        grant = '0;
        if (run_reg) begin
            if (!SINGLE_PORT) begin
                grant = '1;
            end else if (&req_valid) begin
                grant = ptr_reg ? 2'b10 : 2'b01;
            end else begin
                grant = req_valid;
            end
        end
    end

    assign acc   = req_valid & grant;
    assign rd_en = acc & ~req_err & {1'b1, ~bus.d_req_we};
    assign wr_en = acc[0] & ~req_err[0] & bus.d_req_we;

    assign bus.d_req_ready = grant[0];
    assign bus.i_req_ready = grant[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_reg <= 1'b0;
            ptr_reg <= 1'b0;
        end else begin
            run_reg <= 1'b1;
            if (SINGLE_PORT && run_reg && (&req_valid)) begin
                ptr_reg <= ~ptr_reg;
            end
        end
    end

    // Array has no reset so it maps onto block RAM with byte write enables.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (bus.d_req_be[b]) begin
                    mem[req_idx[0]][8*b +: 8] <= bus.d_req_wdata[8*b +: 8];
                end
            end
        end
    end

    for (gi = 0; gi < NP; gi++) begin : g_rsp
        logic [RD_LATENCY-1:0] vld_reg;
        logic [RD_LATENCY-1:0] err_reg;
        logic [RD_LATENCY-1:0] ld_reg;
        logic [DATA_W-1:0]     dat_reg [RD_LATENCY];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_reg <= '0;
                err_reg <= '0;
                ld_reg  <= '0;
            end else begin
                vld_reg[0] <= acc[gi];
                err_reg[0] <= acc[gi] & req_err[gi];
                ld_reg[0]  <= rd_en[gi];
                for (int k = 1; k < RD_LATENCY; k++) begin
                    vld_reg[k] <= vld_reg[k-1];
                    err_reg[k] <= err_reg[k-1];
                    ld_reg[k]  <= ld_reg[k-1];
                end
            end
        end

        // Data stages are unreset; ld_reg qualifies them so stale contents never escape.
        always_ff @(posedge clk) begin
            if (rd_en[gi]) begin
                dat_reg[0] <= mem[req_idx[gi]];
            end
            for (int k = 1; k < RD_LATENCY; k++) begin
                dat_reg[k] <= dat_reg[k-1];
            end
        end

        assign rsp_valid[gi] = vld_reg[RD_LATENCY-1];
        assign rsp_err[gi]   = err_reg[RD_LATENCY-1];
        assign rsp_data[gi]  = ld_reg[RD_LATENCY-1] ? dat_reg[RD_LATENCY-1] : '0;
    end

    assign bus.d_rsp_valid = rsp_valid[0];
    assign bus.d_rsp_err   = rsp_err[0];
    assign bus.d_rsp_rdata = rsp_data[0];
    assign bus.i_rsp_valid = rsp_valid[1];
    assign bus.i_rsp_err   = rsp_err[1];
    assign bus.i_rsp_data  = rsp_data[1];
endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Bench for unified_mem_ctrl: a dual-port latency-1 instance and a single-port latency-3
// instance driven side by side and checked against a word-array reference model.
module tb_unified_mem_ctrl;
    localparam int DEPTH = 256;
    localparam int NDUT  = 2;

    typedef struct {
        int          due;
        logic        err;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    unified_mem_if #(.DATA_W(32), .ADDR_W(32)) bus0 ();
    unified_mem_if #(.DATA_W(32), .ADDR_W(32)) bus1 ();

    unified_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH), .RD_LATENCY(1), .SINGLE_PORT(1'b0))
        u_dual (.clk(clk), .rst_n(rst_n), .bus(bus0));
    unified_mem_ctrl #(.DATA_W(32), .ADDR_W(32), .DEPTH_WORDS(DEPTH), .RD_LATENCY(3), .SINGLE_PORT(1'b1))
        u_shared (.clk(clk), .rst_n(rst_n), .bus(bus1));

    logic        iv  [NDUT];
    logic [31:0] ia  [NDUT];
    logic        dv  [NDUT];
    logic        dwe [NDUT];
    logic [3:0]  dbe [NDUT];
    logic [31:0] da  [NDUT];
    logic [31:0] dwd [NDUT];
    logic        ir  [NDUT];
    logic        irv [NDUT];
    logic        ie  [NDUT];
    logic [31:0] id  [NDUT];
    logic        dr  [NDUT];
    logic        drv [NDUT];
    logic        de  [NDUT];
    logic [31:0] dd  [NDUT];

    assign bus0.i_req_valid = iv[0];
    assign bus0.i_req_addr  = ia[0];
    assign bus0.d_req_valid = dv[0];
    assign bus0.d_req_we    = dwe[0];
    assign bus0.d_req_be    = dbe[0];
    assign bus0.d_req_addr  = da[0];
    assign bus0.d_req_wdata = dwd[0];
    assign ir[0]  = bus0.i_req_ready;
    assign irv[0] = bus0.i_rsp_valid;
    assign ie[0]  = bus0.i_rsp_err;
    assign id[0]  = bus0.i_rsp_data;
    assign dr[0]  = bus0.d_req_ready;
    assign drv[0] = bus0.d_rsp_valid;
    assign de[0]  = bus0.d_rsp_err;
    assign dd[0]  = bus0.d_rsp_rdata;

    assign bus1.i_req_valid = iv[1];
    assign bus1.i_req_addr  = ia[1];
    assign bus1.d_req_valid = dv[1];
    assign bus1.d_req_we    = dwe[1];
    assign bus1.d_req_be    = dbe[1];
    assign bus1.d_req_addr  = da[1];
    assign bus1.d_req_wdata = dwd[1];
    assign ir[1]  = bus1.i_req_ready;
    assign irv[1] = bus1.i_rsp_valid;
    assign ie[1]  = bus1.i_rsp_err;
    assign id[1]  = bus1.i_rsp_data;
    assign dr[1]  = bus1.d_req_ready;
    assign drv[1] = bus1.d_rsp_valid;
    assign de[1]  = bus1.d_rsp_err;
    assign dd[1]  = bus1.d_rsp_rdata;

    // Reference model: plain word array per instance plus expected-response queues.
    logic [31:0] mm [NDUT][DEPTH];
    exp_t        qd [NDUT][$];
    exp_t        qi [NDUT][$];
    bit          turn_i [NDUT];
    bit          acc_d  [NDUT];
    bit          acc_i  [NDUT];
    logic        gnt_i_obs [NDUT];
    logic [31:0] last_ld [NDUT];
    logic [31:0] last_if [NDUT];
    logic [3:0]  gseq;

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic bit bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a >= 32'(DEPTH * 4));
    endfunction

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return 32'(DEPTH * 4) + 32'($urandom_range(0, 63));
        if (r == 1) return (32'($urandom_range(0, DEPTH - 1)) * 4) | 32'($urandom_range(1, 3));
        return 32'($urandom_range(0, DEPTH - 1)) * 4;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic set_d(input int k, input logic we, input logic [3:0] be,
                         input logic [31:0] a, input logic [31:0] wd);
        dv[k] = 1'b1; dwe[k] = we; dbe[k] = be; da[k] = a; dwd[k] = wd;
    endtask

    task automatic set_i(input int k, input logic [31:0] a);
        iv[k] = 1'b1; ia[k] = a;
    endtask

    task automatic rsp_check(input int k, input bit fetch);
        exp_t        e;
        logic        v;
        logic        er;
        logic [31:0] dat;
        bit          due;
        string       nm;
        v   = fetch ? irv[k] : drv[k];
        er  = fetch ? ie[k]  : de[k];
        dat = fetch ? id[k]  : dd[k];
        nm  = $sformatf("dut%0d %s", k, fetch ? "i_rsp" : "d_rsp");
        if (fetch) due = (qi[k].size() > 0) && (qi[k][0].due == cyc);
        else       due = (qd[k].size() > 0) && (qd[k][0].due == cyc);
        if (due) begin
            if (fetch) e = qi[k].pop_front();
            else       e = qd[k].pop_front();
            check({nm, " valid"}, 32'(v), 32'd1);
            check({nm, " err"}, 32'(er), 32'(e.err));
            check({nm, " data"}, dat, e.data);
            $display("txn dut%0d %s we=%0d addr=%h err=%0d data=%h", k, fetch ? "fetch" : "data ",
                     e.we, e.addr, er, dat);
            if (fetch && !e.err) last_if[k] = dat;
            if (!fetch && !e.we && !e.err) last_ld[k] = dat;
        end else begin
            check({nm, " idle valid"}, 32'(v), 32'd0);
            check({nm, " idle data"}, dat, 32'd0);
        end
    endtask

    // One clock: check handshakes, update the model, advance, check responses.
    task automatic tick();
        bit   gd;
        bit   gf;
        exp_t e;
        int   w;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            if (k == 0) begin
                gd = 1'b1; gf = 1'b1;
            end else if (dv[k] && iv[k]) begin
                gd = !turn_i[k]; gf = turn_i[k];
            end else begin
                gd = dv[k]; gf = iv[k];
            end
            gnt_i_obs[k] = ir[k];
            if (dv[k]) check($sformatf("dut%0d d_req_ready", k), 32'(dr[k]), 32'(gd));
            if (iv[k]) check($sformatf("dut%0d i_req_ready", k), 32'(ir[k]), 32'(gf));
            acc_d[k] = dv[k] && gd;
            acc_i[k] = iv[k] && gf;
            if (acc_i[k]) begin
                e.due = cyc + lat(k); e.we = 1'b0; e.addr = ia[k];
                e.err = bad_addr(ia[k]); e.data = '0;
                if (!e.err) e.data = mm[k][int'(ia[k] >> 2)];
                qi[k].push_back(e);
            end
            if (acc_d[k]) begin
                e.due = cyc + lat(k); e.we = dwe[k]; e.addr = da[k];
                e.err = bad_addr(da[k]); e.data = '0;
                if (!e.err) begin
                    w = int'(da[k] >> 2);
                    if (dwe[k]) begin
                        for (int b = 0; b < 4; b++) begin
                            if (dbe[k][b]) mm[k][w][8*b +: 8] = dwd[k][8*b +: 8];
                        end
                    end else begin
                        e.data = mm[k][w];
                    end
                end
                qd[k].push_back(e);
            end
            if (k == 1 && dv[k] && iv[k]) turn_i[k] = !turn_i[k];
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            if (acc_d[k]) dv[k] = 1'b0;
            if (acc_i[k]) iv[k] = 1'b0;
            rsp_check(k, 1'b0);
            rsp_check(k, 1'b1);
        end
    endtask

    task automatic drain();
        int  n;
        bit  busy;
        n = 0;
        busy = 1'b1;
        while (busy && n < 40) begin
            busy = 1'b0;
            for (int k = 0; k < NDUT; k++) begin
                if (dv[k] || iv[k] || qd[k].size() > 0 || qi[k].size() > 0) busy = 1'b1;
            end
            if (busy) begin
                tick();
                n++;
            end
        end
        check("drain within bound", 32'(n < 40), 32'd1);
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            iv[k] = 1'b0; ia[k] = '0; dv[k] = 1'b0; dwe[k] = 1'b0; dbe[k] = '0;
            da[k] = '0; dwd[k] = '0; turn_i[k] = 1'b0; last_ld[k] = '0; last_if[k] = '0;
        end
        gseq = '0;
        rst_n = 1'b0;
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("dut%0d reset d_req_ready", k), 32'(dr[k]), 32'd0);
            check($sformatf("dut%0d reset i_req_ready", k), 32'(ir[k]), 32'd0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();

        // Preload every word of both arrays with full-word stores.
        for (int w = 0; w < DEPTH; w++) begin
            set_d(0, 1'b1, 4'hF, 32'(w * 4), $urandom());
            set_d(1, 1'b1, 4'hF, 32'(w * 4), $urandom());
            tick();
        end
        drain();

        // Fetch of a freshly stored word.
        set_d(0, 1'b1, 4'hF, 32'h40, 32'hDEADBEEF);
        tick();
        set_i(0, 32'h40);
        tick();
        drain();
        check("dut0 fetch 0x40 data", last_if[0], 32'hDEADBEEF);

        // Byte-strobe store then load on the following cycle.
        set_d(0, 1'b1, 4'hF, 32'h80, 32'hAAAAAAAA);
        tick();
        set_d(0, 1'b1, 4'b0101, 32'h80, 32'h11223344);
        tick();
        set_d(0, 1'b0, 4'h0, 32'h80, 32'h0);
        tick();
        drain();
        check("dut0 strobe merge load", last_ld[0], 32'hAA22AA44);

        // Fetch and store to one word in the same cycle, then load it back.
        set_d(0, 1'b1, 4'hF, 32'h100, 32'hCAFEF00D);
        set_i(0, 32'h100);
        tick();
        set_d(0, 1'b0, 4'h0, 32'h100, 32'h0);
        tick();
        drain();
        check("dut0 load after same-cycle store", last_ld[0], 32'hCAFEF00D);

        // Misaligned and out-of-range accesses on both instances.
        for (int k = 0; k < NDUT; k++) set_d(k, 1'b0, 4'h0, 32'h82, 32'h0);
        drain();
        for (int k = 0; k < NDUT; k++) set_d(k, 1'b1, 4'hF, 32'h82, 32'h55555555);
        drain();
        for (int k = 0; k < NDUT; k++) set_d(k, 1'b1, 4'hF, 32'(DEPTH * 4), 32'h66666666);
        drain();
        for (int k = 0; k < NDUT; k++) set_i(k, 32'h3);
        drain();
        for (int k = 0; k < NDUT; k++) set_i(k, 32'(DEPTH * 4 + 4));
        drain();
        for (int k = 0; k < NDUT; k++) set_d(k, 1'b0, 4'h0, 32'h80, 32'h0);
        drain();
        check("dut0 word 0x80 untouched by errored store", last_ld[0], 32'hAA22AA44);

        // Latency-3 back-to-back fetches.
        set_i(1, 32'h0);
        tick();
        set_i(1, 32'h4);
        tick();
        set_i(1, 32'h8);
        tick();
        drain();

        // Contested single-port arbitration from the post-reset pointer.
        for (int n = 0; n < 4; n++) begin
            if (!dv[1]) set_d(1, 1'b0, 4'h0, 32'($urandom_range(0, DEPTH - 1)) * 4, 32'h0);
            if (!iv[1]) set_i(1, 32'($urandom_range(0, DEPTH - 1)) * 4);
            tick();
            gseq = {gseq[2:0], gnt_i_obs[1]};
        end
        check("dut1 contested grant order D,I,D,I", 32'(gseq), 32'(4'b0101));
        drain();

        // Random mixed traffic.
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < NDUT; k++) begin
                if (!dv[k] && $urandom_range(0, 99) < 60)
                    set_d(k, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), rand_addr(), $urandom());
                if (!iv[k] && $urandom_range(0, 99) < 60) set_i(k, rand_addr());
            end
            tick();
        end
        drain();

        // Reset with responses in flight: outputs clear at once, nothing appears later.
        set_d(0, 1'b1, 4'hF, 32'h20, 32'h0BADF00D);
        set_i(1, 32'h10);
        tick();
        set_i(1, 32'h14);
        tick();
        set_i(1, 32'h18);
        set_d(0, 1'b0, 4'h0, 32'h20, 32'h0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("dut%0d async reset i_rsp_valid", k), 32'(irv[k]), 32'd0);
            check($sformatf("dut%0d async reset d_rsp_valid", k), 32'(drv[k]), 32'd0);
            check($sformatf("dut%0d async reset i_rsp_data", k), id[k], 32'd0);
            check($sformatf("dut%0d async reset d_rsp_rdata", k), dd[k], 32'd0);
            check($sformatf("dut%0d async reset d_req_ready", k), 32'(dr[k]), 32'd0);
            qd[k].delete();
            qi[k].delete();
            dv[k] = 1'b0;
            iv[k] = 1'b0;
            turn_i[k] = 1'b0;
        end
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;
        for (int n = 0; n < 5; n++) tick();

        gseq = '0;
        for (int n = 0; n < 2; n++) begin
            if (!dv[1]) set_d(1, 1'b0, 4'h0, 32'h20, 32'h0);
            if (!iv[1]) set_i(1, 32'h40);
            tick();
            gseq = {gseq[2:0], gnt_i_obs[1]};
        end
        check("dut1 grant order after reset", 32'(gseq[1:0]), 32'(2'b01));
        drain();
        set_d(0, 1'b0, 4'h0, 32'h20, 32'h0);
        drain();
        check("dut0 store kept across reset", last_ld[0], 32'h0BADF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
